y86_run_ctrl: RTL and testbench
===============================

// Module: y86_run_ctrl
// PURPOSE
//  Run controller on the consumer end of the y86 core's 2-bit status output.
//  Starts the core, gates it with a clock enable, counts executed cycles and
//  stops on the first non-AOK status, a cycle-budget timeout or an abort.
//  Latches an exit code for the harness or a host. Sits beside the core and
//  shares its clock.
// PARAMETERS
//  CNT_W       32    cycle counter width
//  MAX_CYCLES  1000  cycle budget (0 = no timeout); must be < 2**CNT_W
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      1-cycle request to begin a run (honoured in IDLE only)
//  abort        in   1      force stop (honoured in RUN only)
//  clear        in   1      return from DONE to IDLE; zeroes counter and code
//  status       in   2      core status: 00 AOK, 01 HLT, 10 ADR, 11 INS
//  cpu_en       out  1      core clock enable; registered; high only in RUN
//  busy         out  1      high in RUN
//  done         out  1      high in DONE (level, not pulse)
//  exit_code    out  3      000 none, 001 HLT, 010 ADR, 011 INS, 100 TIMEOUT, 101 ABORT
//  cycle_count  out  CNT_W  number of enabled cycles in the current/last run
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; cpu_en=0, busy=0, done=0,
//    exit_code=000, cycle_count=0. Reset mid-run discards the run at once.
//  - State encoding: IDLE, RUN, DONE. All outputs are decoded from registered
//    state, so there is no combinational path from input to output.
//  - IDLE: start=1 at edge k -> RUN after edge k; cpu_en=1 in cycle k+1.
//    abort/clear are ignored in IDLE.
//  - RUN: every edge increments cycle_count (saturates at all-ones). status
//    is sampled at the same edge. Exit priority, highest first:
//      1. abort=1                       -> DONE, code 101
//      2. status!=00                    -> DONE, code = {1'b0, status}
//      3. MAX_CYCLES!=0 and
//         cycle_count==MAX_CYCLES-1     -> DONE, code 100
//    The exiting edge still increments the count, so a fault seen in the Nth
//    enabled cycle leaves cycle_count=N. cpu_en drops in the cycle after that
//    edge. start is ignored in RUN.
//  - DONE: cpu_en=0; exit_code and cycle_count hold. clear=1 -> IDLE with
//    count=0 and code=000. start and abort are ignored. If start and clear
//    are both high, only the clear takes effect; a new start is needed in IDLE.
//  - status is don't-care outside RUN. An X on status in RUN is a bench error.
//  - Counter wrap: it never wraps; it holds at 2**CNT_W-1.
// TESTING
//  1. Reset, start pulse, status=AOK for 4 enabled cycles then 01 -> done=1,
//     exit_code=001, cycle_count=5, cpu_en low in the next cycle.
//  2. MAX_CYCLES=8, status held 00 -> done after 8 enabled cycles,
//     exit_code=100, cycle_count=8.
//  3. Abort and status=11 on the same edge in RUN -> exit_code=101 (abort wins).
//  4. Status=10 on the last budgeted cycle (count=MAX_CYCLES-1) -> exit_code=010,
//     not 100.
//  5. In DONE: pulse start -> no change. Pulse clear -> IDLE, count=0, code=000.
//     Start again -> fresh run.
//  6. Drop rst_n mid-RUN between clock edges -> outputs go to reset values
//     immediately. After release the block stays IDLE until the next start.

Source files
------------

// File: rtl/y86_run_ctrl.sv
// y86_run_ctrl: run controller for the y86 core, driven by the core's 2-bit status.
// Starts a run, gates the core with cpu_en and counts the enabled cycles.
// A run stops on abort, on the first non-AOK status or when the cycle budget
// runs out, and an exit code is latched for the harness.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        begin a run (IDLE only)
//   abort        force stop (RUN only)
//   clear        DONE -> IDLE, zeroes cycle_count and exit_code
//   status       core status: 00 AOK, 01 HLT, 10 ADR, 11 INS
//   cpu_en       core clock enable, high in RUN
//   busy / done  high in RUN / high in DONE
//   exit_code    000 none, 001 HLT, 010 ADR, 011 INS, 100 TIMEOUT, 101 ABORT
//   cycle_count  enabled cycles in the current or last run
module y86_run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             clear,
    input  logic [1:0]       status,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic [2:0]       exit_code,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // The budget check compares the count before this edge's increment,
    // so the run ends after exactly MAX_CYCLES enabled cycles.
    localparam bit              TMO_EN = MAX_CYCLES != 0;
    localparam logic [CNT_W-1:0] LAST  = TMO_EN ? CNT_W'(MAX_CYCLES - 1) : '0;
    state_t           state, state_nx;
    logic [2:0]       code_nx;
    logic [CNT_W-1:0] cnt_nx;
    always_comb begin
        state_nx = state;
        code_nx  = exit_code;
        cnt_nx   = cycle_count;
        case (state)
            IDLE: state_nx = start ? RUN : IDLE;
            RUN: begin
                cnt_nx = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
                if (abort) begin
                    state_nx = DONE;
                    code_nx  = 3'b101;
                end else if (status != 2'b00) begin
                    state_nx = DONE;
                    code_nx  = {1'b0, status};
                end else if (TMO_EN && cycle_count == LAST) begin
                    state_nx = DONE;
                    code_nx  = 3'b100;
                end
            end
            DONE: if (clear) begin
                state_nx = IDLE;
                code_nx  = '0;
                cnt_nx   = '0;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            exit_code   <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            exit_code   <= code_nx;
            cycle_count <= cnt_nx;
        end
    end
    assign cpu_en = state == RUN;
    assign busy   = state == RUN;
    assign done   = state == DONE;
endmodule

// File: tb/tb_y86_run_ctrl.sv
// tb_y86_run_ctrl: randomized self-checking bench for y86_run_ctrl against a run-level model.
module tb_y86_run_ctrl;
    localparam int MAXC = 8;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, clear = 0;
    logic [1:0]  status = 0;
    logic        cpu_en, busy, done;
    logic [2:0]  exit_code;
    logic [31:0] cycle_count;
    int checks = 0, failures = 0;
    logic       ab [MAXC];
    logic [1:0] st [MAXC];

    y86_run_ctrl #(.CNT_W(32), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clear(clear),
        .status(status), .cpu_en(cpu_en), .busy(busy), .done(done),
        .exit_code(exit_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_arr();
        for (int i = 0; i < MAXC; i++) begin
            ab[i] = 0;
            st[i] = 0;
        end
    endtask

    // Model: the run ends at the first cycle with abort or a fault, else at the
    // last budgeted cycle; the count is the number of cycles up to and including it.
    task automatic run_arrays();
        int ex;
        logic [2:0] code;
        ex = -1;
        code = 3'b100;
        for (int i = 0; i < MAXC; i++)
            if (ex < 0) begin
                if (ab[i]) begin ex = i; code = 3'b101; end
                else if (st[i] != 0) begin ex = i; code = {1'b0, st[i]}; end
            end
        if (ex < 0) ex = MAXC - 1;
        start = 1;
        status = 2'($urandom);
        step();
        start = 0;
        check("run_busy", busy, 1);
        check("run_cpu_en", cpu_en, 1);
        check("run_cnt0", cycle_count, 0);
        for (int i = 0; i <= ex; i++) begin
            abort = ab[i];
            status = st[i];
            start = 1'($urandom_range(0, 1));
            clear = 1'($urandom_range(0, 1));
            step();
            check("run_count", cycle_count, i + 1);
            if (i < ex) check("run_still_busy", busy, 1);
        end
        abort = 0;
        start = 0;
        clear = 0;
        check("done", done, 1);
        check("done_cpu_en", cpu_en, 0);
        check("done_busy", busy, 0);
        check("exit_code", exit_code, code);
        check("final_count", cycle_count, ex + 1);
        repeat (2) begin
            start = 1;
            abort = 1;
            status = 2'($urandom);
            step();
            check("hold_done", done, 1);
            check("hold_code", exit_code, code);
            check("hold_count", cycle_count, ex + 1);
        end
        abort = 0;
        clear = 1;
        start = 1'($urandom_range(0, 1));
        step();
        clear = 0;
        start = 0;
        check("clr_done", done, 0);
        check("clr_busy", busy, 0);
        check("clr_count", cycle_count, 0);
        check("clr_code", exit_code, 0);
        abort = 1;
        clear = 1;
        step();
        abort = 0;
        clear = 0;
        check("idle_stays", busy, 0);
        check("idle_not_done", done, 0);
    endtask

    initial begin
        #12;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_code", exit_code, 0);
        check("rst_count", cycle_count, 0);
        rst_n = 1;
        step();
        clr_arr(); st[4] = 2'b01; run_arrays();
        clr_arr(); run_arrays();
        clr_arr(); ab[2] = 1; st[2] = 2'b11; run_arrays();
        clr_arr(); st[MAXC-1] = 2'b10; run_arrays();
        clr_arr(); ab[0] = 1; run_arrays();
        repeat (20) begin
            for (int i = 0; i < MAXC; i++) begin
                ab[i] = $urandom_range(0, 15) == 0;
                st[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            run_arrays();
        end
        start = 1;
        step();
        start = 0;
        status = 0;
        step();
        step();
        #3 rst_n = 0;
        #1;
        check("arst_cpu_en", cpu_en, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_code", exit_code, 0);
        check("arst_count", cycle_count, 0);
        #2 rst_n = 1;
        repeat (3) begin
            step();
            check("post_rst_idle", busy, 0);
            check("post_rst_count", cycle_count, 0);
        end
        clr_arr(); st[1] = 2'b01; run_arrays();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
